// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map and FSM encoding shared by the sequential ALU
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHLB = 4'd6;
  localparam logic [3:0] OP_SHRB = 4'd7;
  localparam logic [3:0] OP_LAND = 4'd8;
  localparam logic [3:0] OP_LOR  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_AND  = 4'd12;
  localparam logic [3:0] OP_OR   = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;
  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: WIDTH-step restoring unsigned divider, one quotient bit per cycle
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] shl, trial;
  // q/r are the post-step values so the caller can capture them on the final step edge
  assign shl = {rem, quo[WIDTH-1]};
  assign trial = shl - {1'b0, dvs};
  assign q = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign r = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
  assign done = busy && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rem <= '0;
      quo <= a;
      dvs <= b;
      cnt <= CW'(WIDTH - 1);
    end else if (busy) begin
      rem <= r;
      quo <= q;
      cnt <= cnt - CW'(1);
      busy <= ~done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered 16-op ALU with valid/ready handshakes, flags and iterative divide
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);
  state_t state, nxt;
  logic accept, div_go, dmod, d_busy, d_done, c_c, c_v, c_dz;
  logic [WIDTH-1:0] d_q, d_r, d_res, nb, c_res, c_hi;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] prod;
  assign in_ready = state == IDLE || (state == HOLD && out_ready);
  assign out_valid = state == HOLD;
  assign accept = in_valid && in_ready;
  assign div_go = accept && (op == OP_DIV || op == OP_MOD) && |b;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign nb = -b;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign d_res = dmod ? d_r : d_q;
  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst(rst), .start(div_go), .a(a), .b(b),
    .busy(d_busy), .done(d_done), .q(d_q), .r(d_r)
  );
  always_comb begin
    c_res = '0;
    c_hi = '0;
    c_c = 1'b0;
    c_v = 1'b0;
    c_dz = 1'b0;
    case (op)
      OP_ADD: begin
        c_res = sum[WIDTH-1:0];
        c_c = sum[WIDTH];
        c_v = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        c_res = diff[WIDTH-1:0];
        c_c = diff[WIDTH];
        c_v = a[WIDTH-1] == nb[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      OP_MUL: {c_hi, c_res} = prod;
      // only reached with b == 0; nonzero divisors go through the iterative divider
      OP_DIV: begin
        c_res = '1;
        c_dz = 1'b1;
      end
      OP_MOD: begin
        c_res = a;
        c_dz = 1'b1;
      end
      OP_SHRA: c_res = a >> 1;
      OP_SHLB: c_res = b << 1;
      OP_SHRB: c_res = b >> 1;
      OP_LAND: c_res = WIDTH'(|a && |b);
      OP_LOR:  c_res = WIDTH'(|a || |b);
      OP_XOR:  c_res = a ^ b;
      OP_NOT:  c_res = ~a;
      OP_AND:  c_res = a & b;
      OP_OR:   c_res = a | b;
      OP_GT:   c_res = WIDTH'(a > b);
      OP_EQ:   c_res = WIDTH'(a == b);
      default: ;
    endcase
  end
  always_comb begin
    nxt = state;
    if (state == DIV) nxt = d_done ? HOLD : d_busy ? DIV : IDLE;
    else if (accept) nxt = div_go ? DIV : HOLD;
    else if (state == HOLD && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res <= '0;
      res_hi <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_dz <= 1'b0;
      dmod <= 1'b0;
    end else begin
      state <= nxt;
      if (accept && !div_go) begin
        res <= c_res;
        res_hi <= c_hi;
        flag_z <= c_res == '0;
        flag_c <= c_c;
        flag_v <= c_v;
        flag_dz <= c_dz;
      end else if (state == DIV && d_done) begin
        res <= d_res;
        res_hi <= '0;
        flag_z <= d_res == '0;
        flag_c <= 1'b0;
        flag_v <= 1'b0;
        flag_dz <= 1'b0;
      end
      if (div_go) dmod <= op == OP_MOD;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed vectors
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic flag_z, flag_c, flag_v, flag_dz;
  logic [3:0] op;
  logic [W-1:0] a, b, res, res_hi;
  typedef struct {
    string nm;
    logic [19:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int pop_cyc[$];
  int pass_n = 0;
  int total_n = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .res_hi(res_hi), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
  );
  function automatic logic [19:0] pk(logic [7:0] r, logic [7:0] h, logic z, logic c, logic v, logic dz);
    return {h, r, z, c, v, dz};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // outputs are packed {res_hi, res, z, c, v, dz}
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_result: got res=%0h with nothing expected", res);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.nm, 32'(pk(res, res_hi, flag_z, flag_c, flag_v, flag_dz)), 32'(mon_e.exp));
        pop_cyc.push_back(cyc);
      end
    end
  end
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input string nm, input logic [19:0] e, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    if (push) sb.push_back('{nm, e});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic div_run(input logic [3:0] o, input string nm, input logic [7:0] r);
    int n = 0;
    int lowc = 0;
    issue(o, 8'd200, 8'd7, nm, pk(r, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    while (!out_valid && n < 20) begin
      if (!in_ready) lowc++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n + 1), 32'd9);
    chk({nm, "_in_ready_low"}, 32'(lowc), 32'd8);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", 32'(pk(res, res_hi, flag_z, flag_c, flag_v, flag_dz)), 32'd0);
    rst = 1'b0;
    issue(OP_ADD, 8'd200, 8'd100, "add_carry", pk(8'd44, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(OP_SUB, 8'h80, 8'h01, "sub_ovf", pk(8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(OP_SUB, 8'd5, 8'd7, "sub_borrow", pk(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(OP_MUL, 8'hFF, 8'hFF, "mul_max", pk(8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    div_run(OP_DIV, "div", 8'd28);
    div_run(OP_MOD, "mod", 8'd4);
    issue(OP_DIV, 8'd9, 8'd0, "div_zero", pk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(OP_MOD, 8'd9, 8'd0, "mod_zero", pk(8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    drain();
    out_ready = 1'b0;
    issue(OP_XOR, 8'hA5, 8'h0F, "xor_bp", pk(8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    repeat (5) begin
      chk("bp_res", 32'(res), 32'hAA);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(OP_AND,  8'hF0, 8'h3C, "and",  pk(8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_OR,   8'hF0, 8'h3C, "or",   pk(8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_EQ,   8'd5,  8'd5,  "eq",   pk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_GT,   8'd3,  8'd9,  "gt",   pk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_NOT,  8'h0F, 8'h00, "not",  pk(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_LAND, 8'h00, 8'h05, "land", pk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_SHRA, 8'h81, 8'h00, "shra", pk(8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_SHRB, 8'h00, 8'h81, "shrb", pk(8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_LOR,  8'h00, 8'h00, "lor",  pk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(OP_SHLB, 8'h00, 8'h81, "shlb", pk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();
    chk("b2b_count", 32'(pop_cyc.size() >= 10), 32'd1);
    if (pop_cyc.size() >= 10) begin
      k = pop_cyc.size() - 10;
      for (int i = 1; i < 10; i++) chk("b2b_spacing", 32'(pop_cyc[k+i] - pop_cyc[k+i-1]), 32'd1);
    end
    issue(OP_DIV, 8'd200, 8'd7, "div_rst", 20'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_div_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_in_ready", 32'(in_ready), 32'd1);
    chk("rst_div_res", 32'(res), 32'd0);
    rst = 1'b0;
    repeat (12) begin
      chk("rst_div_no_result", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    issue(OP_ADD, 8'd1, 8'd1, "add_after_rst", pk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU. Same 16-op opcode map as the team's combinational ALU, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, status flags, full-width multiply high half, and a multi-cycle restoring divider for / and %.
- Sits between an operand-issue stage and a result-writeback stage. Backpressure is honoured on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- OPW, 4, opcode width (fixed map below; must be 4).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  OPW  opcode.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  consumer takes result.
- res  out  WIDTH  result (low half for multiply, quotient for /, remainder for %).
- res_hi  out  WIDTH  high half of A*B; 0 for all other ops.
- flag_z  out  1  res == 0.
- flag_c  out  1  add: carry out; sub: borrow (a < b); else 0.
- flag_v  out  1  add/sub signed (two's complement) overflow; else 0.
- flag_dz  out  1  / or % with b == 0.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. It is sampled on the rising edge and overrides everything, including an in-flight divide.
- Reset values: state=IDLE, out_valid=0, res=0, res_hi=0, all flags 0. in_ready=1 in the first cycle after reset.
- Opcode map, with results zero-extended to WIDTH:
  - 0 add; 1 sub (mod 2^WIDTH); 2 mul (2*WIDTH product split res_hi:res).
  - 3 div; 4 mod.
  - 5 a>>1; 6 b<<1; 7 b>>1 (logical).
  - 8 logical AND ((a!=0)&&(b!=0)); 9 logical OR (both as 1/0).
  - 10 a^b; 11 ~a; 12 a&b; 13 a|b.
  - 14 a>b unsigned (1/0); 15 a==b (1/0).
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - Output is held stable while out_valid && !out_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- FSM states IDLE, DIV, HOLD:
  - IDLE/HOLD + accept, op not 3/4: compute into output regs. Go to HOLD with out_valid=1 next cycle (latency 1).
  - IDLE/HOLD + accept, op 3/4, b!=0: latch a, b, op; clear partial remainder; counter=WIDTH-1. Go to DIV with out_valid=0.
  - DIV: one restoring-divide step per cycle. After WIDTH steps, load res (quotient or remainder) and go to HOLD with out_valid=1. Latency is WIDTH+1 cycles from accept. in_ready=0 throughout DIV.
  - Divide by zero (op 3/4, b==0): no DIV state; latency 1.
    - res = all-ones for /, a for %.
    - flag_dz=1, flag_z per res.
  - HOLD + out_ready + no new accept: go to IDLE, out_valid=0.
  - HOLD + !out_ready: stay; all outputs frozen.
- Width rules:
  - flag_c from the WIDTH+1-bit sum/difference.
  - flag_v = sign(a)==sign(b') && sign(res)!=sign(a), with b'=b for add, ~b+1 for sub.
- Unused opcodes: none. All 16 are defined.
- Reset during DIV or HOLD: result is discarded and out_valid drops next cycle.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_EQ), state enum/encoding (IDLE, DIV, HOLD).
- One sub-module: alu_div_iter. It is the iterative WIDTH-step unsigned divider with start/busy/done, quotient and remainder outputs, and synchronous rst.
- Single-cycle ops stay inline in alu_seq.

Test Plan:
- WIDTH=8, add a=200 b=100, out_ready=1 -> one cycle later res=44, flag_c=1, flag_v=0, flag_z=0.
- sub a=0x80 b=0x01 -> res=0x7F, flag_v=1, flag_c=0; then sub a=5 b=7 -> res=0xFE, flag_c=1.
- mul a=0xFF b=0xFF -> res_hi=0xFE, res=0x01.
- div a=200 b=7:
  - in_ready low for 8 cycles; out_valid exactly 9 cycles after accept with res=28.
  - repeat with mod -> res=4.
- div a=9 b=0 -> 1 cycle later res=0xFF, flag_dz=1; mod a=9 b=0 -> res=9, flag_dz=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after xor a=0xA5 b=0x0F: res=0xAA stable, in_ready=0.
  - Issue new ops back-to-back once out_ready=1: one result/cycle.
  - Assert rst mid-DIV: next cycle out_valid=0, in_ready=1, res=0.
